rib_rr_arbiter: RTL and testbench
=================================

// Module: rib_rr_arbiter
// PURPOSE
//  Round-robin bus arbiter that shares the rib slave fabric between NM masters
//  (core0/core1 ex ports and JTAG ports).
//  - Registered one-hot grant; per-master hold feeds the core hold_flag inputs.
//  - Bounded burst length: no master can starve the others.
//  - Sits between the master request lines and the rib mux select.
// PARAMETERS
//  NM         4  number of masters (>=2)
//  IDXW       2  width of grant index, = clog2(NM)
//  MAX_BURST  8  max consecutive grant cycles for one owner while others wait (>=1)
// PORTS
//  clk          in   1     clock, all logic on rising edge
//  rst          in   1     synchronous reset, active-high
//  req_i        in   NM    per-master request, level, held until served
//  last_i       in   NM    owner's final cycle of its transfer sequence
//  grant_o      out  NM    one-hot grant, registered
//  grant_idx_o  out  IDXW  binary index of grant_o, valid when grant_vld_o
//  grant_vld_o  out  1     some master currently granted (= |grant_o)
//  hold_o       out  NM    req_i & ~grant_o, combinational stall to each master
//  busy_o       out  1     FSM in GRANT state
// BEHAVIOUR
//  Reset: grant_o=0, grant_idx_o=0, grant_vld_o=0, busy_o=0, ptr=NM-1,
//   burst_cnt=0, state=IDLE.
//  - rst sampled high mid-transfer drops the grant at that same edge.
//  - hold_o=req_i while in reset.
//  Round-robin pick: first i with req_i[i]=1, scanning ptr+1, ptr+2, ... mod NM.
//  FSM IDLE:
//  - any req_i -> GRANT with winner (grant_o visible 1 cycle after req_i seen).
//  - else stay in IDLE.
//  FSM GRANT, owner o, release when any of:
//  - (a) req_i[o]=0
//  - (b) last_i[o]=1
//  - (c) burst_cnt==MAX_BURST-1 and some req_i[j]=1, j!=o
//  On release:
//  - ptr<=o, burst_cnt<=0.
//  - if another master requests, grant it at the next edge (no idle bubble).
//  - else go to IDLE with grant_o=0.
//  - re-pick excludes o in case (c). In cases (a)/(b), o is eligible again only
//    if no other master requests.
//  No release: burst_cnt increments, saturating at MAX_BURST-1.
//  - An owner with no competition may hold the grant indefinitely.
//  - (c) fires as soon as a competitor appears once saturated.
//  Simultaneous last_i[o] and new requests: handled as a release with an
//   immediate handover; a second requester waits exactly one more arbitration.
//  last_i/req_i of non-owners are ignored for release decisions.
//  grant_o is always one-hot or zero; never changes except on an edge.
//  Worst-case wait for a requester: (NM-1)*MAX_BURST cycles after raising req.
// CONFIGURATION
//  RIB_ARB_PRIO_EN defined:
//  - master 0 (debug/JTAG) wins every arbitration point where req_i[0]=1,
//    regardless of ptr.
//  - (c) also fires for any owner !=0 when req_i[0]=1 and burst_cnt>=1.
//  - master 0 is never preempted by (c).
//  - ptr is not updated when master 0 releases.
//  RIB_ARB_PRIO_EN undefined: pure round-robin, master 0 is an ordinary requester.
// TESTING
//  1 Reset: rst=1 for 2 cycles with req_i=4'b1111 -> grant_o=0, hold_o=4'b1111,
//    busy_o=0; release rst -> grant_o=4'b0001 one cycle later.
//  2 Rotation: req_i=4'b1111 held, last_i pulsed each grant cycle
//    -> grants 0001,0010,0100,1000,0001 on consecutive cycles.
//  3 Burst cap: req_i[1] held alone for 20 cycles -> grant stays 0010;
//    raise req_i[2] at cycle 20 -> grant 0100 on the next edge
//    (MAX_BURST=8 already saturated).
//  4 Drop: owner 2 drops req_i mid-burst with nothing else pending
//    -> next cycle grant_o=0, busy_o=0; req_i[3] next -> grant 1000 after 1 cycle.
//  5 Mid-op reset: rst pulsed while grant 0100 -> grant_o=0 at that edge;
//    afterwards req_i=4'b0110 -> grant 0010 (ptr=NM-1).
//  6 RIB_ARB_PRIO_EN: owner 1 in cycle 3 of burst, raise req_i[0]
//    -> grant 0001 next edge.
//    Without the macro -> owner 1 keeps the grant until last_i or burst cap.

Source files
------------

// File: rtl/rib_rr_arbiter.sv
// rib_rr_arbiter: round-robin arbiter sharing the rib slave fabric among NM masters.
// Latency: grant_o is registered, visible one cycle after req_i is seen; handover has no idle bubble.
// Backpressure: hold_o = req_i & ~grant_o stalls each waiting master; a burst cap bounds any owner.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   req_i[NM]    per-master request level, held until served
//   last_i[NM]   owner's final cycle of its transfer sequence
//   grant_o[NM]  registered one-hot grant (or zero)
//   grant_idx_o  binary index of grant_o, meaningful when grant_vld_o
//   grant_vld_o  some master currently granted
//   hold_o[NM]   combinational stall per master
//   busy_o       arbiter in GRANT state
//
// Option: define RIB_ARB_PRIO_EN to give master 0 (debug/JTAG) strict priority.
module rib_rr_arbiter #(
  parameter int NM        = 4,
  parameter int IDXW      = 2,
  parameter int MAX_BURST = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NM-1:0]   req_i,
  input  logic [NM-1:0]   last_i,
  output logic [NM-1:0]   grant_o,
  output logic [IDXW-1:0] grant_idx_o,
  output logic            grant_vld_o,
  output logic [NM-1:0]   hold_o,
  output logic            busy_o
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          r_state, w_state_nxt;
  logic [NM-1:0]   r_grant, w_grant_nxt;
  logic [IDXW-1:0] r_ptr, w_ptr_nxt;
  logic [CW-1:0]   r_burst_cnt, w_burst_nxt;

  logic [IDXW-1:0] w_owner_idx;
  logic [NM-1:0]   w_others;
  logic            w_own_req;
  logic            w_own_last;
  logic            w_any_other;
  logic            w_cap;
  logic            w_release;

  // First requester in mask scanning ptr+1, ptr+2, ... mod NM.
  function automatic logic [NM-1:0] f_pick(input logic [NM-1:0] mask,
                                           input logic [IDXW-1:0] ptr);
    logic [NM-1:0] res;
    logic          found;
    int            idx;
    res   = '0;
    found = 1'b0;
    for (int k = 1; k <= NM; k++) begin
      idx = (int'(ptr) + k) % NM;
      if (!found && mask[idx]) begin
        res[idx] = 1'b1;
        found    = 1'b1;
      end
    end
`ifdef RIB_ARB_PRIO_EN
    if (mask[0]) res = NM'(1);
`endif
    return res;
  endfunction

  always_comb begin
    w_owner_idx = '0;
    for (int i = 0; i < NM; i++) begin
      if (r_grant[i]) w_owner_idx = w_owner_idx | IDXW'(i);
    end
  end

  // Only the owner's own req/last lines take part in release decisions.
  assign w_own_req   = |(req_i & r_grant);
  assign w_own_last  = |(last_i & r_grant);
  assign w_others    = req_i & ~r_grant;
  assign w_any_other = |w_others;

`ifdef RIB_ARB_PRIO_EN
  // Master 0 is never capped; any other owner yields to master 0 after one cycle.
  assign w_cap = ~r_grant[0] &
                 (((r_burst_cnt == CNT_MAX) & w_any_other) |
                  (req_i[0] & (r_burst_cnt != '0)));
`else
  assign w_cap = (r_burst_cnt == CNT_MAX) & w_any_other;
`endif

  assign w_release = ~w_own_req | w_own_last | w_cap;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_burst_nxt = r_burst_cnt;
    case (r_state)
      S_IDLE: begin
        if (|req_i) begin
          w_grant_nxt = f_pick(req_i, r_ptr);
          w_state_nxt = S_GRANT;
          w_burst_nxt = '0;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_burst_nxt = '0;
`ifdef RIB_ARB_PRIO_EN
          if (!r_grant[0]) w_ptr_nxt = w_owner_idx;
`else
          w_ptr_nxt = w_owner_idx;
`endif
          if (w_any_other) begin
            // Competitors exist: hand over immediately, owner excluded.
            w_grant_nxt = f_pick(w_others, w_ptr_nxt);
          end else if (w_own_req) begin
            // Sole requester finished a sequence and asks again: re-grant.
            w_grant_nxt = r_grant;
          end else begin
            w_grant_nxt = '0;
            w_state_nxt = S_IDLE;
          end
        end else if (r_burst_cnt != CNT_MAX) begin
          w_burst_nxt = r_burst_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_ptr       <= IDXW'(NM - 1);
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_ptr       <= w_ptr_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  assign grant_o     = r_grant;
  assign grant_idx_o = w_owner_idx;
  assign grant_vld_o = |r_grant;
  assign hold_o      = req_i & ~r_grant;
  assign busy_o      = (r_state == S_GRANT);

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// tb_rib_rr_arbiter: directed bench for rib_rr_arbiter (NM=4, MAX_BURST=8).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: checks hold_o alongside grant_o in each scenario.
module tb_rib_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_i;
  logic [3:0] last_i;
  logic [3:0] grant_o;
  logic [1:0] grant_idx_o;
  logic       grant_vld_o;
  logic [3:0] hold_o;
  logic       busy_o;

  int checks;
  int failures;

  rib_rr_arbiter #(.NM(4), .IDXW(2), .MAX_BURST(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .last_i      (last_i),
    .grant_o     (grant_o),
    .grant_idx_o (grant_idx_o),
    .grant_vld_o (grant_vld_o),
    .hold_o      (hold_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    req_i  = 4'b0000;
    last_i = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    req_i  = 4'b1111;
    last_i = 4'b0000;
    tick();
    tick();
    checks++;
    if (grant_o !== 4'b0000 || busy_o !== 1'b0 || grant_vld_o !== 1'b0 || grant_idx_o !== 2'd0) begin
      failures++;
      $display("FAIL reset_state grant=%b busy=%b vld=%b idx=%0d expected grant=0000 busy=0 vld=0 idx=0",
               grant_o, busy_o, grant_vld_o, grant_idx_o);
    end
    checks++;
    if (hold_o !== 4'b1111) begin
      failures++;
      $display("FAIL reset_hold got=%b expected=1111", hold_o);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (grant_o !== 4'b0001 || grant_idx_o !== 2'd0 || busy_o !== 1'b1 || hold_o !== 4'b1110) begin
      failures++;
      $display("FAIL reset_first_grant grant=%b idx=%0d busy=%b hold=%b expected 0001 0 1 1110",
               grant_o, grant_idx_o, busy_o, hold_o);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [5];
    logic [1:0] exp_i [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_i = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req_i  = 4'b1111;
    last_i = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (grant_o !== exp_g[n] || grant_idx_o !== exp_i[n] || hold_o !== (4'b1111 & ~exp_g[n])) begin
        failures++;
        $display("FAIL rotation_%0d grant=%b idx=%0d hold=%b expected grant=%b idx=%0d",
                 n, grant_o, grant_idx_o, hold_o, exp_g[n], exp_i[n]);
      end
    end
  endtask

  task automatic test_burst_cap();
    int bad;
    do_reset();
    req_i = 4'b0010;
    bad   = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (grant_o !== 4'b0010) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL burst_alone_hold bad_cycles=%0d expected=0 last_grant=%b", bad, grant_o);
    end
    req_i = 4'b0110;
    tick();
    checks++;
    if (grant_o !== 4'b0100 || hold_o !== 4'b0010) begin
      failures++;
      $display("FAIL burst_cap_handover grant=%b hold=%b expected grant=0100 hold=0010", grant_o, hold_o);
    end
  endtask

  task automatic test_drop();
    do_reset();
    req_i = 4'b0100;
    tick();
    tick();
    tick();
    checks++;
    if (grant_o !== 4'b0100) begin
      failures++;
      $display("FAIL drop_owner grant=%b expected=0100", grant_o);
    end
    req_i = 4'b0000;
    tick();
    checks++;
    if (grant_o !== 4'b0000 || busy_o !== 1'b0 || grant_vld_o !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle grant=%b busy=%b vld=%b expected 0000 0 0", grant_o, busy_o, grant_vld_o);
    end
    req_i = 4'b1000;
    tick();
    checks++;
    if (grant_o !== 4'b1000 || grant_idx_o !== 2'd3 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL drop_regrant grant=%b idx=%0d busy=%b expected 1000 3 1", grant_o, grant_idx_o, busy_o);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    req_i = 4'b0100;
    tick();
    checks++;
    if (grant_o !== 4'b0100) begin
      failures++;
      $display("FAIL midrst_owner grant=%b expected=0100", grant_o);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (grant_o !== 4'b0000 || busy_o !== 1'b0 || hold_o !== 4'b0100) begin
      failures++;
      $display("FAIL midrst_drop grant=%b busy=%b hold=%b expected 0000 0 0100", grant_o, busy_o, hold_o);
    end
    rst   = 1'b0;
    req_i = 4'b0110;
    tick();
    checks++;
    if (grant_o !== 4'b0010) begin
      failures++;
      $display("FAIL midrst_ptr grant=%b expected=0010", grant_o);
    end
  endtask

  task automatic test_prio();
    int bad;
    do_reset();
    req_i = 4'b0010;
    tick();
    tick();
    tick();
    req_i = 4'b0011;
`ifdef RIB_ARB_PRIO_EN
    tick();
    checks++;
    if (grant_o !== 4'b0001) begin
      failures++;
      $display("FAIL prio_preempt grant=%b expected=0001", grant_o);
    end
`else
    bad = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (grant_o !== 4'b0010) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL noprio_keep bad_cycles=%0d expected=0 grant=%b", bad, grant_o);
    end
    tick();
    checks++;
    if (grant_o !== 4'b0001) begin
      failures++;
      $display("FAIL noprio_cap grant=%b expected=0001", grant_o);
    end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_i = 4'b0010;
    tick();
    req_i  = 4'b1110;
    last_i = 4'b0010;
    tick();
    checks++;
    if (grant_o !== 4'b0100 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_handover grant=%b busy=%b expected 0100 1", grant_o, busy_o);
    end
    last_i = 4'b0000;
    req_i  = 4'b1010;
    tick();
    checks++;
    if (grant_o !== 4'b1000) begin
      failures++;
      $display("FAIL b2b_second grant=%b expected=1000", grant_o);
    end
  endtask

  task automatic test_regrant();
    int bad;
    do_reset();
    req_i  = 4'b0001;
    last_i = 4'b0001;
    bad    = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (grant_o !== 4'b0001 || busy_o !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL regrant_sole bad_cycles=%0d expected=0 grant=%b", bad, grant_o);
    end
    last_i = 4'b0000;
    req_i  = 4'b0000;
    tick();
    checks++;
    if (grant_o !== 4'b0000 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL regrant_release grant=%b busy=%b expected 0000 0", grant_o, busy_o);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req_i    = 4'b0000;
    last_i   = 4'b0000;
    test_reset();
    test_rotation();
    test_burst_cap();
    test_drop();
    test_mid_reset();
    test_prio();
    test_back_to_back();
    test_regrant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
